// File: rtl/la_capture_core.sv
// la_capture_core: masked level/edge triggered circular-buffer capture with trigger-relative readout
module la_capture_core #(
    parameter int DATA_W = 78,
    parameter int TRIG_W = 8,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [AW-1:0]     pretrig_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_value_i,
    input  logic [TRIG_W-1:0] trig_edge_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [2:0]        state_o,
    output logic              triggered_o,
    output logic              done_o,
    output logic [AW-1:0]     trig_pos_o,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, WAIT = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
    localparam logic [AW-1:0] ONE = 1;
    state_t state_q, state_d;
    logic [AW-1:0] pretrig_q, pretrig_d, wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, trig_pos_q, trig_pos_d;
    logic [TRIG_W-1:0] mask_q, mask_d, value_q, value_d, edge_q, edge_d, prev_q, prev_d, bit_ok;
    logic hist_q, hist_d, triggered_q, triggered_d, done_q, done_d, rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic sampling, fire, rd_fire;
    logic [AW-1:0] post_len, rd_phys;
    always_comb begin
        sampling = state_q inside {PRE, WAIT, POST};
        // DEPTH - pretrig - 1 is the bitwise complement for a power-of-two depth
        post_len = ~pretrig_q;
        bit_ok = ~mask_q | (~(trig_i ^ value_q) & (~edge_q | (hist_q ? (prev_q ^ value_q) : '0)));
        fire = (state_q == WAIT) && (&bit_ok);
        rd_fire = (state_q == DONE) && rd_en_i;
        rd_phys = trig_pos_q - pretrig_q + rd_addr_i;
        rd_valid_d = rd_fire;
        state_d = state_q;
        pretrig_d = pretrig_q;
        mask_d = mask_q;
        value_d = value_q;
        edge_d = edge_q;
        wr_ptr_d = sampling ? wr_ptr_q + ONE : wr_ptr_q;
        cnt_d = cnt_q;
        trig_pos_d = trig_pos_q;
        triggered_d = triggered_q;
        done_d = done_q;
        prev_d = sampling ? trig_i : prev_q;
        hist_d = hist_q | sampling;
        if (abort_i) begin
            state_d = IDLE;
            triggered_d = 1'b0;
            done_d = 1'b0;
        end else if (arm_i && (state_q == IDLE || state_q == DONE)) begin
            pretrig_d = pretrig_i;
            mask_d = trig_mask_i;
            value_d = trig_value_i;
            edge_d = trig_edge_i;
            triggered_d = 1'b0;
            done_d = 1'b0;
            wr_ptr_d = '0;
            cnt_d = '0;
            hist_d = 1'b0;
            state_d = (pretrig_i == '0) ? WAIT : PRE;
        end else if (state_q == PRE) begin
            cnt_d = cnt_q + ONE;
            state_d = (cnt_q == pretrig_q - ONE) ? WAIT : PRE;
        end else if (fire) begin
            trig_pos_d = wr_ptr_q;
            triggered_d = 1'b1;
            cnt_d = '0;
            done_d = (post_len == '0);
            state_d = (post_len == '0) ? DONE : POST;
        end else if (state_q == POST) begin
            cnt_d = cnt_q + ONE;
            done_d = (cnt_q == post_len - ONE);
            state_d = (cnt_q == post_len - ONE) ? DONE : POST;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pretrig_q <= '0;
            mask_q <= '0;
            value_q <= '0;
            edge_q <= '0;
            wr_ptr_q <= '0;
            cnt_q <= '0;
            trig_pos_q <= '0;
            triggered_q <= 1'b0;
            done_q <= 1'b0;
            prev_q <= '0;
            hist_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pretrig_q <= pretrig_d;
            mask_q <= mask_d;
            value_q <= value_d;
            edge_q <= edge_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q <= cnt_d;
            trig_pos_q <= trig_pos_d;
            triggered_q <= triggered_d;
            done_q <= done_d;
            prev_q <= prev_d;
            hist_q <= hist_d;
            rd_valid_q <= rd_valid_d;
        end
    end
    // Simple dual-port RAM: unreset write port, registered read port
    always_ff @(posedge clk_i) begin
        if (sampling) mem[wr_ptr_q] <= data_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) rd_data_q <= '0;
        else if (rd_fire) rd_data_q <= mem[rd_phys];
    end
    assign state_o = state_q;
    assign triggered_o = triggered_q;
    assign done_o = done_q;
    assign trig_pos_o = trig_pos_q;
    assign rd_data_o = rd_data_q;
    assign rd_valid_o = rd_valid_q;
endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: directed capture scenarios on a 16-deep buffer with hand-computed expectations
module tb_la_capture_core;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        arm_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [3:0]  pretrig_i = '0;
    logic [7:0]  trig_mask_i = '0;
    logic [7:0]  trig_value_i = '0;
    logic [7:0]  trig_edge_i = '0;
    logic [7:0]  trig_i = '0;
    logic [77:0] data_i = '0;
    logic [2:0]  state_o;
    logic        triggered_o;
    logic        done_o;
    logic [3:0]  trig_pos_o;
    logic        rd_en_i = 1'b0;
    logic [3:0]  rd_addr_i = '0;
    logic [77:0] rd_data_o;
    logic        rd_valid_o;
    logic        auto_trig = 1'b1;
    int nvec = 0;
    int nmis = 0;

    la_capture_core #(.DATA_W(78), .TRIG_W(8), .DEPTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
        .pretrig_i(pretrig_i), .trig_mask_i(trig_mask_i), .trig_value_i(trig_value_i),
        .trig_edge_i(trig_edge_i), .trig_i(trig_i), .data_i(data_i),
        .state_o(state_o), .triggered_o(triggered_o), .done_o(done_o),
        .trig_pos_o(trig_pos_o), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [77:0] got, input logic [77:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        data_i = data_i + 1;
        if (auto_trig) trig_i = data_i[7:0];
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic arm(input logic [3:0] pt, input logic [7:0] m, input logic [7:0] v, input logic [7:0] e);
        pretrig_i = pt;
        trig_mask_i = m;
        trig_value_i = v;
        trig_edge_i = e;
        arm_i = 1'b1;
        @(posedge clk_i);
        #1;
        arm_i = 1'b0;
        data_i = '0;
        if (auto_trig) trig_i = '0;
    endtask

    task automatic rd(input int a, input logic [77:0] exp);
        rd_en_i = 1'b1;
        rd_addr_i = 4'(a);
        tick();
        rd_en_i = 1'b0;
        chk($sformatf("rd_valid[%0d]", a), rd_valid_o, 1);
        chk($sformatf("rd_data[%0d]", a), rd_data_o, exp);
    endtask

    initial begin
        ticks(3);
        rst_i = 1'b0;
        chk("rst_state", state_o, 0);
        chk("rst_trig", triggered_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_pos", trig_pos_o, 0);
        chk("rst_rdata", rd_data_o, 0);
        chk("rst_rvalid", rd_valid_o, 0);

        // level trigger, pretrig 4, value 20
        arm(4, 8'hFF, 8'd20, 8'h00);
        chk("s1_pre", state_o, 1);
        ticks(3);
        chk("s1_pre3", state_o, 1);
        tick();
        chk("s1_wait", state_o, 2);
        ticks(16);
        chk("s1_notrig", triggered_o, 0);
        tick();
        chk("s1_post", state_o, 3);
        chk("s1_trig", triggered_o, 1);
        chk("s1_pos", trig_pos_o, 4);
        ticks(10);
        chk("s1_post10", state_o, 3);
        chk("s1_nodone", done_o, 0);
        tick();
        chk("s1_done_st", state_o, 4);
        chk("s1_done", done_o, 1);
        for (int i = 0; i < 16; i++) rd(i, 78'(16 + i));

        // zero pretrig, all-zero mask
        arm(0, 8'h00, 8'h00, 8'h00);
        chk("s2_wait", state_o, 2);
        tick();
        chk("s2_post", state_o, 3);
        chk("s2_pos", trig_pos_o, 0);
        ticks(14);
        chk("s2_post14", state_o, 3);
        tick();
        chk("s2_done", done_o, 1);
        for (int i = 0; i < 16; i++) rd(i, 78'(i));

        // edge trigger on bit 0, held high at arm
        auto_trig = 1'b0;
        trig_i = 8'h01;
        arm(0, 8'h01, 8'h01, 8'h01);
        ticks(3);
        chk("s3_held", triggered_o, 0);
        trig_i = 8'h00;
        tick();
        chk("s3_low", triggered_o, 0);
        trig_i = 8'h01;
        tick();
        chk("s3_fire", triggered_o, 1);
        chk("s3_pos", trig_pos_o, 4);
        chk("s3_post", state_o, 3);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("s3_abort_st", state_o, 0);
        chk("s3_abort_trig", triggered_o, 0);
        auto_trig = 1'b1;

        // maximum pretrig, trigger at sample 40
        arm(15, 8'hFF, 8'd40, 8'h00);
        ticks(40);
        chk("s4_wait", state_o, 2);
        tick();
        chk("s4_done_st", state_o, 4);
        chk("s4_done", done_o, 1);
        chk("s4_pos", trig_pos_o, 8);
        rd(15, 40);
        rd(0, 25);
        rd(7, 32);

        // re-arm from DONE, abort with arm in WAIT, arm ignored in POST
        arm(2, 8'hFF, 8'd200, 8'h00);
        chk("s5_rearm_st", state_o, 1);
        chk("s5_rearm_done", done_o, 0);
        chk("s5_rearm_trig", triggered_o, 0);
        ticks(4);
        chk("s5_wait", state_o, 2);
        abort_i = 1'b1;
        arm_i = 1'b1;
        tick();
        abort_i = 1'b0;
        arm_i = 1'b0;
        chk("s5_abort_st", state_o, 0);
        chk("s5_abort_done", done_o, 0);
        chk("s5_abort_trig", triggered_o, 0);
        arm(0, 8'hFF, 8'd3, 8'h00);
        ticks(4);
        chk("s5_post", state_o, 3);
        chk("s5_pos", trig_pos_o, 3);
        pretrig_i = 4'd5;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("s5_arm_ign", state_o, 3);
        ticks(13);
        chk("s5_post_end", state_o, 3);
        tick();
        chk("s5_done", done_o, 1);
        rd(0, 3);
        rd(15, 18);

        // reset in POST
        arm(0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("s6_post", state_o, 3);
        rd_en_i = 1'b1;
        rd_addr_i = 4'd2;
        tick();
        rd_en_i = 1'b0;
        chk("s6_rd_post_valid", rd_valid_o, 0);
        chk("s6_rd_post_hold", rd_data_o, 18);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("s6_state", state_o, 0);
        chk("s6_trig", triggered_o, 0);
        chk("s6_done", done_o, 0);
        chk("s6_pos", trig_pos_o, 0);
        chk("s6_rdata", rd_data_o, 0);
        chk("s6_rvalid", rd_valid_o, 0);
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        chk("s6_idle_rvalid", rd_valid_o, 0);
        chk("s6_idle_rdata", rd_data_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
